// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_SHIFT     = 2;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned WORD_W         = 32;

    // Byte address of a word index.
    function automatic logic [WORD_W-1:0] word_to_addr(input logic [WORD_W-1:0] idx);
        return idx << ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; pulses word_valid
// for one cycle after the fourth byte, with word held until the next one.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc,
    input  logic [7:0]        din,
    output logic [LANE_W-1:0] lane,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [7:0] b0, b1, b2;

    // Lane counter, partial-byte holding registers and completed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= '0;
            b0         <= '0;
            b1         <= '0;
            b2         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                lane <= '0;
            end else if (acc) begin
                case (lane)
                    2'd0: b0 <= din;
                    2'd1: b1 <= din;
                    2'd2: b2 <= din;
                    default: begin
                        word       <= {din, b2, b1, b0};
                        word_valid <= 1'b1;
                    end
                endcase
                lane <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: byte stream in, word writes out,
// core held in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LEN_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_words,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              we,
    output logic [31:0]       wa,
    output logic [31:0]       wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst
);

    localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [31:0]       wa_d;
    logic              s_ready_d, busy_d, done_d, err_d, cpu_rst_d;

    logic              acc_c;
    logic              last_byte_c;
    logic              clr_c;
    logic              too_long_c;
    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] pk_word;
    logic              pk_valid;

    assign acc_c       = s_valid & s_ready;
    assign last_byte_c = acc_c && (lane == LAST_LANE);
    assign too_long_c  = 32'(len_words) > 32'(DEPTH_WORDS);

    // Byte lane assembly; its registered word/strobe are the write port.
    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clr        (clr_c),
        .acc        (acc_c),
        .din        (s_data),
        .lane       (lane),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    assign we = pk_valid;
    assign wd = pk_word;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        wa_d      = wa;
        s_ready_d = s_ready;
        busy_d    = busy;
        done_d    = done;
        err_d     = err;
        cpu_rst_d = cpu_rst;
        clr_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Release the core one cycle after the last write lands.
                if (state_q == ST_DONE) begin
                    cpu_rst_d = done;
                end
                if (start) begin
                    clr_c     = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b0;
                    if (len_words == '0) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b1;
                    end else if (too_long_c) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ST_LOAD;
                        len_d     = CNT_W'(len_words);
                        wcnt_d    = '0;
                        s_ready_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (last_byte_c) begin
                    wa_d   = word_to_addr(32'(wcnt_q));
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if (wcnt_q == len_q - CNT_W'(1)) begin
                        state_d   = ST_DONE;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                s_ready_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                err_d     = 1'b0;
                cpu_rst_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            wa      <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cpu_rst <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            wa      <= wa_d;
            s_ready <= s_ready_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            cpu_rst <= cpu_rst_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len_words;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst;

    int n_tests = 0;
    int n_fail  = 0;
    int we_total = 0;
    int base;

    imem_loader #(.DEPTH_WORDS(1024), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len_words (len_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst   (cpu_rst)
    );

    always #5 clk = ~clk;

    // Count memory writes as the memory would see them.
    always @(posedge clk) begin
        if (we === 1'b1) we_total <= we_total + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        step();
    endtask

    task automatic do_start(input logic [15:0] len);
        s_valid   = 1'b0;
        start     = 1'b1;
        len_words = len;
        step();
        start     = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        len_words = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        step();
        step();

        // Reset values
        chk1 ("rst_s_ready", s_ready, 1'b0);
        chk1 ("rst_we",      we,      1'b0);
        chk32("rst_wa",      wa,      32'h0);
        chk32("rst_wd",      wd,      32'h0);
        chk1 ("rst_busy",    busy,    1'b0);
        chk1 ("rst_done",    done,    1'b0);
        chk1 ("rst_err",     err,     1'b0);
        chk1 ("rst_cpu_rst", cpu_rst, 1'b0);
        rst = 1'b1;
        step();

        // Single word
        base = we_total;
        do_start(16'd1);
        chk1("t1_busy",    busy,    1'b1);
        chk1("t1_s_ready", s_ready, 1'b1);
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'h50);
        chk1("t1_no_early_we", we, 1'b0);
        send_byte(8'h00);
        s_valid = 1'b0;
        chk1 ("t1_we",      we,      1'b1);
        chk32("t1_wa",      wa,      32'h0);
        chk32("t1_wd",      wd,      32'h00500513);
        chk1 ("t1_done",    done,    1'b1);
        chk1 ("t1_busy_lo", busy,    1'b0);
        chk1 ("t1_ready_lo", s_ready, 1'b0);
        chk1 ("t1_cpu_rst_held", cpu_rst, 1'b0);
        step();
        chk1 ("t1_we_pulse", we,      1'b0);
        chk1 ("t1_cpu_rst", cpu_rst, 1'b1);
        chk32("t1_writes",  32'(we_total - base), 32'd1);

        // Three words, back-to-back bytes
        base = we_total;
        do_start(16'd3);
        chk1("t2_done_clr", done, 1'b0);
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(i + 1));
            chk1("t2_we", we, ((i % 4) == 3));
            if ((i % 4) == 3) begin
                chk32("t2_wa", wa, 32'((i / 4) * 4));
                chk32("t2_wd", wd, {8'(i + 1), 8'(i), 8'(i - 1), 8'(i - 2)});
            end
        end
        chk32("t2_wd_last", wd, 32'h0C0B0A09);
        chk1("t2_done",    done,    1'b1);
        chk1("t2_busy_lo", busy,    1'b0);
        chk1("t2_ready_lo", s_ready, 1'b0);
        chk1("t2_cpu_rst_held", cpu_rst, 1'b0);
        send_byte(8'hEE);
        chk1("t2_extra_ready", s_ready, 1'b0);
        chk1("t2_extra_we",    we,      1'b0);
        chk1("t2_cpu_rst",     cpu_rst, 1'b1);
        send_byte(8'hEE);
        s_valid = 1'b0;
        chk32("t2_writes", 32'(we_total - base), 32'd3);

        // Stalled stream
        base = we_total;
        do_start(16'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        s_valid = 1'b0;
        step();
        step();
        step();
        chk1("t3_stall_we",   we,   1'b0);
        chk1("t3_stall_busy", busy, 1'b1);
        send_byte(8'h33);
        chk1("t3_no_early_we", we, 1'b0);
        send_byte(8'h44);
        chk1 ("t3_we0", we, 1'b1);
        chk32("t3_wa0", wa, 32'h0);
        chk32("t3_wd0", wd, 32'h44332211);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        chk32("t3_wd_hold", wd, 32'h44332211);
        send_byte(8'hDD);
        s_valid = 1'b0;
        chk32("t3_wa1", wa, 32'h4);
        chk32("t3_wd1", wd, 32'hDDCCBBAA);
        chk1 ("t3_done", done, 1'b1);
        step();
        chk32("t3_writes", 32'(we_total - base), 32'd2);

        // Zero length
        base = we_total;
        do_start(16'd0);
        chk1("t4_zero_done",    done,    1'b1);
        chk1("t4_zero_cpu_rst", cpu_rst, 1'b1);
        chk1("t4_zero_err",     err,     1'b0);
        chk1("t4_zero_busy",    busy,    1'b0);

        // Over-length
        do_start(16'd1025);
        chk1("t4_long_err",     err,     1'b1);
        chk1("t4_long_done",    done,    1'b0);
        chk1("t4_long_cpu_rst", cpu_rst, 1'b0);
        step();
        chk1("t4_long_cpu_rst2", cpu_rst, 1'b0);
        chk32("t4_no_writes", 32'(we_total - base), 32'd0);

        // Full-depth image
        base = we_total;
        do_start(16'd1024);
        chk1("t4_full_err_clr", err, 1'b0);
        for (int i = 0; i < 4096; i++) begin
            send_byte(8'(i));
        end
        s_valid = 1'b0;
        chk1 ("t4_full_we",   we,   1'b1);
        chk32("t4_full_wa",   wa,   32'h00000FFC);
        chk32("t4_full_wd",   wd,   32'hFFFEFDFC);
        chk1 ("t4_full_done", done, 1'b1);
        step();
        chk1 ("t4_full_cpu_rst", cpu_rst, 1'b1);
        chk32("t4_full_writes", 32'(we_total - base), 32'd1024);

        // Reset mid-load
        do_start(16'd4);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h40 + i));
        end
        chk32("t5_pre_wd", wd, 32'h43424140);
        rst = 1'b0;
        #1;
        chk1 ("t5_rst_s_ready", s_ready, 1'b0);
        chk1 ("t5_rst_we",      we,      1'b0);
        chk32("t5_rst_wa",      wa,      32'h0);
        chk32("t5_rst_wd",      wd,      32'h0);
        chk1 ("t5_rst_busy",    busy,    1'b0);
        chk1 ("t5_rst_done",    done,    1'b0);
        chk1 ("t5_rst_cpu_rst", cpu_rst, 1'b0);
        s_valid = 1'b0;
        step();
        step();
        rst  = 1'b1;
        base = we_total;
        step();
        step();
        step();
        chk32("t5_no_we_after_rst", 32'(we_total - base), 32'd0);
        do_start(16'd1);
        send_byte(8'h93);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        s_valid = 1'b0;
        chk1 ("t5_we", we, 1'b1);
        chk32("t5_wa", wa, 32'h0);
        chk32("t5_wd", wd, 32'h00100093);
        step();
        chk1 ("t5_cpu_rst", cpu_rst, 1'b1);

        // Restart from DONE, with a stray start during LOAD
        do_start(16'd1);
        chk1("t6_done_clr",    done,    1'b0);
        chk1("t6_cpu_rst_clr", cpu_rst, 1'b0);
        chk1("t6_busy",        busy,    1'b1);
        send_byte(8'h01);
        send_byte(8'h02);
        start     = 1'b1;
        len_words = 16'd0;
        send_byte(8'h03);
        start     = 1'b0;
        chk1("t6_start_ignored_busy", busy, 1'b1);
        chk1("t6_start_ignored_done", done, 1'b0);
        send_byte(8'h04);
        s_valid = 1'b0;
        chk1 ("t6_we",   we,   1'b1);
        chk32("t6_wa",   wa,   32'h0);
        chk32("t6_wd",   wd,   32'h04030201);
        chk1 ("t6_done", done, 1'b1);
        step();
        chk1 ("t6_cpu_rst", cpu_rst, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and drives the instruction memory write port at consecutive word addresses starting at 0. Holds the pipeline core in reset until the programmed image is complete. Sits between the host/debug link and the instruction memory write side; the fetch path keeps the read side (`A` → `RD`).

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: instruction memory capacity in 32-bit words.
- `LEN_W`, 16: width of the word-count input.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load; sampled only in IDLE and DONE.
- `len_words` in LEN_W: number of words to load; latched when `start` is accepted.
- `s_valid` in 1: byte-stream valid.
- `s_data` in 8: byte-stream data.
- `s_ready` out 1: byte-stream ready.
- `we` out 1: instruction memory write enable; one-cycle pulse per word.
- `wa` out 32: write byte address; word-aligned, so bits [1:0] are always 0.
- `wd` out 32: write data.
- `busy` out 1: high in LOAD.
- `done` out 1: high in DONE after a successful load.
- `err` out 1: high in DONE after a rejected length.
- `cpu_rst` out 1: active-low core reset; 0 holds the core in reset.

## Operation
- **Reset values:** state IDLE; `s_ready`=0, `we`=0, `wa`=0, `wd`=0, `busy`=0, `done`=0, `err`=0, `cpu_rst`=0; byte counter 0, word counter 0.
- **IDLE**
  - `start`, `len_words`=0 → DONE with `done`=1 and `cpu_rst`=1; no writes.
  - `start`, `len_words` > `DEPTH_WORDS` → DONE with `err`=1 and `cpu_rst`=0; no writes.
  - `start` with any other length → LOAD; latch the length, clear both counters, `cpu_rst`=0.
- **LOAD**
  - `s_ready`=1 and `busy`=1.
  - A byte is accepted on a cycle where `s_valid` and `s_ready` are both high.
  - Byte k of a word (k = 0..3) goes into bits [8k+7:8k].
  - On acceptance of byte 3: register `wd`, set `wa` = word_count×4, pulse `we` next cycle, increment word count.
  - When the written word is the last word (word_count = len−1 at its acceptance):
    - `s_ready` drops in the same edge as that acceptance, so no further bytes are taken.
    - The state moves to DONE together with the final `we` pulse.
- **DONE**
  - `done` or `err` is held; `s_ready`=0.
  - `cpu_rst`=1 only when `done`=1.
  - `start` restarts exactly as in IDLE: `done`, `err` and `cpu_rst` clear on the accepting edge.
- `start` during LOAD is ignored.
- Counters are sized from `DEPTH_WORDS`; the word address never wraps, because the length is pre-checked.

## Timing
- Byte throughput is one per cycle; there is no back-pressure inside a load.
- Byte-3 acceptance on edge N produces `we`=1 with `wa`/`wd` valid during cycle N+1; the memory writes on edge N+1.
- `we` is high for exactly one cycle per word; `wa`/`wd` hold their values until the next write.
- Final word:
  - `we`, `done`=1 and `busy`=0 all appear in the same cycle, N+1.
  - `cpu_rst` rises one cycle later, at N+2, so the core never leaves reset before the last write lands.
- Minimum load time for L words is 4L+2 cycles from `start` to `cpu_rst`=1, with `s_valid` held high.
- **Reset mid-LOAD:** all outputs return to their reset values asynchronously. Any partial word is discarded. No `we` pulse follows the deassertion of reset.
- **Gaps in `s_valid`:** partial-word state is held indefinitely.

## Structure
- **Shared package/header:**
  - state encoding: IDLE=2'd0, LOAD=2'd1, DONE=2'd2;
  - constant `BYTES_PER_WORD`=4;
  - `ADDR_SHIFT`=2.
- **Sub-module `imem_word_packer`:**
  - Inputs: byte plus accept strobe, and a clear.
  - Outputs: 2-bit lane counter, 32-bit assembled word, one-cycle `word_valid`.
  - The loader owns the FSM, the address counter, the length check and `cpu_rst`.

## Test plan
- **Single word:** `len_words`=1, bytes 0x13,0x05,0x50,0x00.
  - One `we` with `wa`=0x0, `wd`=0x00500513.
  - `done`=1 in the same cycle; `cpu_rst`=1 one cycle later.
- **Three words, back-to-back bytes:** `len_words`=3.
  - `we` appears on cycles 5, 9 and 13 after `start`.
  - `wa`=0x0, 0x4, 0x8.
  - The stream carries 12 bytes of pattern data, then extra bytes that must not be accepted (`s_ready`=0).
- **Stalled stream:** `len_words`=2 with `s_valid` low for 3 cycles between bytes 1 and 2.
  - Word 0 = 0x44332211 from bytes 11,22,33,44.
  - No early `we` during the stall.
- **Boundary lengths:**
  - `len_words`=0 → `done`=1, `cpu_rst`=1, no `we`.
  - `len_words`=1025 with `DEPTH_WORDS`=1024 → `err`=1, `cpu_rst`=0, no `we`.
  - `len_words`=1024 → final `wa`=0xFFC.
- **Reset mid-load:** `rst`=0 after 6 bytes of a 4-word load.
  - All outputs drop to reset values immediately.
  - After release and a new `start`, the first write has `wa`=0.
- **Restart from DONE:** after a completed 1-word load, pulse `start` with `len_words`=1.
  - `done` and `cpu_rst` drop on the accepting edge.
  - The second image overwrites `wa`=0.
  - `start` pulsed during LOAD has no effect.
